// File: rtl/out_bcd_display.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : out_bcd_display
// Purpose  : Output stage for the CPU `out` port. Each new output word is
//            converted from binary to BCD by a sequential double-dabble
//            engine, one bit per clock. The last result is shown on a
//            scanned, multiplexed 7-segment display.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH : width of the binary input word
//   DIGITS     : number of BCD digits converted and displayed
//   SCAN_DIV   : clock cycles each digit stays enabled (>= 1)
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   in_data  in   binary value from the CPU out port
//   busy     out  conversion in progress (CONV or DONE)
//   valid    out  at least one conversion has completed since reset
//   ovf      out  last result lost a carry out of the top digit
//   bcd      out  last converted result, digit 0 in bits [3:0]
//   seg      out  segments {g,f,e,d,c,b,a}, active-low
//   an       out  digit enables, active-low, one-hot-low
// Build option
//   OUT_BCD_LZ_BLANK_EN : when defined, blank leading zero digits
//                         (digit 0 is always shown)
// ============================================================================
module out_bcd_display #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5,
  parameter int SCAN_DIV   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  busy,
  output logic                  valid,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int BW   = 4 * DIGITS;
  localparam int IT_W = $clog2(DATA_WIDTH + 1);
  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IT_W-1:0] ITER_LAST = IT_W'(DATA_WIDTH - 1);
  localparam logic [SC_W-1:0] SCAN_LAST = SC_W'(SCAN_DIV - 1);
  localparam logic [IX_W-1:0] IDX_LAST  = IX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         work_q, work_d;
  logic [BW-1:0]         work_adj;
  logic                  work_ovf_q, work_ovf_d;
  logic [IT_W-1:0]       iter_q, iter_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;

  logic [SC_W-1:0]       scan_q, scan_d;
  logic [IX_W-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            digit;
  logic                  blank_lz;
`ifdef OUT_BCD_LZ_BLANK_EN
  logic                  lead;
`endif

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift so
  // that it carries correctly into the next decimal digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign work_adj[4*g +: 4] = (work_q[4*g +: 4] >= 4'd5) ?
                                (work_q[4*g +: 4] + 4'd3) : work_q[4*g +: 4];
  end

  // --------------------------------------------------------------------------
  // Conversion FSM, next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    shift_d    = shift_q;
    work_d     = work_q;
    work_ovf_d = work_ovf_q;
    iter_d     = iter_q;
    bcd_d      = bcd_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        // Input changes during CONV/DONE are picked up here, so the final
        // stable value is always converted.
        if (in_data != last_q) begin
          last_d     = in_data;
          shift_d    = in_data;
          work_d     = '0;
          work_ovf_d = 1'b0;
          iter_d     = '0;
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        work_d  = {work_adj[BW-2:0], shift_q[DATA_WIDTH-1]};
        shift_d = shift_q << 1;
        // A bit leaving the top nibble means the value needs more digits
        // than are available; the kept digits are the truncated result.
        if (work_adj[BW-1]) begin
          work_ovf_d = 1'b1;
        end
        iter_d = iter_q + 1'b1;
        if (iter_q == ITER_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = work_q;
        ovf_d   = work_ovf_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Display scanning
  // --------------------------------------------------------------------------
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : (idx_q + 1'b1);
    end
  end

  // Digit select and leading-zero detection work on next-state values so the
  // registered seg and an change on the same edge.
  always_comb begin
    digit    = 4'd0;
    blank_lz = 1'b0;
`ifdef OUT_BCD_LZ_BLANK_EN
    lead     = 1'b1;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef OUT_BCD_LZ_BLANK_EN
      lead = lead & (bcd_d[4*i +: 4] == 4'd0);
`endif
      if (idx_d == IX_W'(i)) begin
        digit = bcd_d[4*i +: 4];
`ifdef OUT_BCD_LZ_BLANK_EN
        blank_lz = lead & (i != 0);
`endif
      end
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    if (valid_d) begin
      an_d = ~(DIGITS'(1) << idx_d);
      if (!blank_lz) begin
        seg_d = seg_decode(digit);
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= '0;
      shift_q    <= '0;
      work_q     <= '0;
      work_ovf_q <= 1'b0;
      iter_q     <= '0;
      bcd_q      <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      scan_q     <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      seg_q      <= 7'h7F;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      work_ovf_q <= work_ovf_d;
      iter_q     <= iter_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign bcd   = bcd_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule
`default_nettype wire

// File: tb/tb_out_bcd_display.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_out_bcd_display
// Purpose  : Self-checking bench for out_bcd_display. A 5-digit and a 4-digit
//            instance share clock, reset and input. Expected conversion
//            results are queued when stimulus is issued and popped by a
//            monitor when busy falls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_out_bcd_display;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;

  logic        busy5, valid5, ovf5;
  logic [19:0] bcd5;
  logic [6:0]  seg5;
  logic [4:0]  an5;

  logic        busy4, valid4, ovf4;
  logic [15:0] bcd4;
  logic [6:0]  seg4;
  logic [3:0]  an4;

  int unsigned cyc;
  int          checks;
  int          errors;
  logic        prev_busy;

  typedef struct {
    logic [19:0] b5;
    logic        o5;
    logic [15:0] b4;
    logic        o4;
    int unsigned done_cyc;
  } exp_t;

  exp_t sbq[$];

  out_bcd_display #(.DATA_WIDTH(16), .DIGITS(5), .SCAN_DIV(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data),
    .busy(busy5), .valid(valid5), .ovf(ovf5), .bcd(bcd5), .seg(seg5), .an(an5)
  );

  out_bcd_display #(.DATA_WIDTH(16), .DIGITS(4), .SCAN_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data),
    .busy(busy4), .valid(valid4), .ovf(ovf4), .bcd(bcd4), .seg(seg4), .an(an4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    logic [6:0] t [0:9];
    t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100; t[3] = 7'b0110000;
    t[4] = 7'b0011001; t[5] = 7'b0010010; t[6] = 7'b0000010; t[7] = 7'b1111000;
    t[8] = 7'b0000000; t[9] = 7'b0010000;
    return (d <= 4'd9) ? t[d] : 7'b1111111;
  endfunction

  // Monitor: a falling busy marks a completed conversion.
  initial prev_busy = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_busy && !busy5) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("bcd5", {12'd0, bcd5}, {12'd0, e.b5});
        chk("ovf5", {31'd0, ovf5}, {31'd0, e.o5});
        chk("valid5", {31'd0, valid5}, 32'd1);
        chk("bcd4", {16'd0, bcd4}, {16'd0, e.b4});
        chk("ovf4", {31'd0, ovf4}, {31'd0, e.o4});
        chk("busy4", {31'd0, busy4}, 32'd0);
      end
    end
    prev_busy = rst_n ? busy5 : 1'b0;
  end

  // Called at a negedge; the following posedge is the capture edge.
  task automatic apply(input logic [15:0] v, input logic [19:0] b5, input logic o5,
                       input logic [15:0] b4, input logic o4);
    exp_t e;
    e.b5 = b5; e.o5 = o5; e.b4 = b4; e.o4 = o4; e.done_cyc = cyc + 18;
    sbq.push_back(e);
    in_data = v;
    @(negedge clk);
    chk("busy_after_capture", {31'd0, busy5}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy5 || sbq.size() != 0) && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (n >= 80) begin
      chk("wait_idle_timeout", 32'd1, 32'd0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_scan(input logic [19:0] v);
    int n;
    logic [4:0] prev_an;
    logic [4:0] exp_an;
    logic [6:0] exp_seg;
    logic       lz;
    n = 0;
    prev_an = an5;
    @(negedge clk);
    while (!(an5 == 5'b11110 && prev_an != 5'b11110) && n < 64) begin
      prev_an = an5;
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      chk("scan_sync_timeout", 32'd1, 32'd0);
    end else begin
      for (int d = 0; d < 5; d++) begin
`ifdef OUT_BCD_LZ_BLANK_EN
        lz = (d > 0) && ((v >> (4 * d)) == 20'd0);
`else
        lz = 1'b0;
`endif
        exp_an  = ~(5'b00001 << d);
        exp_seg = lz ? 7'h7F : ref_seg(v[4*d +: 4]);
        for (int k = 0; k < 4; k++) begin
          chk("scan_an", {27'd0, an5}, {27'd0, exp_an});
          chk("scan_seg", {25'd0, seg5}, {25'd0, exp_seg});
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int unsigned k0;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    in_data = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_bcd", {12'd0, bcd5}, 32'd0);
    chk("rst_ovf", {31'd0, ovf5}, 32'd0);
    chk("rst_an4", {28'd0, an4}, 32'hF);
    chk("rst_seg4", {25'd0, seg4}, 32'h7F);
    rst_n = 1'b1;

    // 1: input equal to reset value -> nothing happens, display dark
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, busy5}, 32'd0);
      chk("idle_valid", {31'd0, valid5}, 32'd0);
      chk("idle_an", {27'd0, an5}, 32'h1F);
      chk("idle_seg", {25'd0, seg5}, 32'h7F);
    end

    // 2: basic conversion and display
    apply(16'd1234, 20'h01234, 1'b0, 16'h1234, 1'b0);
    wait_idle();
    check_scan(20'h01234);

    // 3: full scale; the 4-digit instance truncates
    apply(16'hFFFF, 20'h65535, 1'b0, 16'h5535, 1'b1);
    wait_idle();
    check_scan(20'h65535);

    // 4: input changes mid-conversion, picked up afterwards
    k0 = cyc;
    apply(16'd5, 20'h00005, 1'b0, 16'h0005, 1'b0);
    @(negedge clk);
    @(negedge clk);
    in_data = 16'd7;
    e.b5 = 20'h00007; e.o5 = 1'b0; e.b4 = 16'h0007; e.o4 = 1'b0; e.done_cyc = k0 + 36;
    sbq.push_back(e);
    wait_idle();
    check_scan(20'h00007);

    apply(16'd9876, 20'h09876, 1'b0, 16'h9876, 1'b0);
    wait_idle();
    check_scan(20'h09876);

    // 6: reset in the middle of a conversion
    in_data = 16'd4321;
    @(negedge clk);
    repeat (8) @(negedge clk);
    chk("mid_conv_busy", {31'd0, busy5}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy5}, 32'd0);
    chk("arst_valid", {31'd0, valid5}, 32'd0);
    chk("arst_ovf4", {31'd0, ovf4}, 32'd0);
    chk("arst_bcd", {12'd0, bcd5}, 32'd0);
    chk("arst_an", {27'd0, an5}, 32'h1F);
    chk("arst_seg", {25'd0, seg5}, 32'h7F);
    in_data = 16'd1234;
    repeat (2) @(negedge clk);
    e.b5 = 20'h01234; e.o5 = 1'b0; e.b4 = 16'h1234; e.o4 = 1'b0; e.done_cyc = cyc + 18;
    sbq.push_back(e);
    rst_n = 1'b1;
    @(negedge clk);
    chk("busy_after_release", {31'd0, busy5}, 32'd1);
    wait_idle();
    check_scan(20'h01234);

    if (sbq.size() != 0) begin
      chk("scoreboard_empty", sbq.size(), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
